// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's bus signals: the ALU and LSU result
// offers, the register-file write port, the flush strobe and the pending mask.
interface wb_arbiter_if;
   logic        flush;

   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;

   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        mem_ready;

   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic [31:0] pending_mask;

   // Arbiter side
   modport slave (
      input  flush,
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      output alu_ready, mem_ready,
      output wb_valid, wb_rd, wb_data,
      output pending_mask
   );

   // Producer / consumer side
   modport master (
      output flush,
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      input  alu_ready, mem_ready,
      input  wb_valid, wb_rd, wb_data,
      input  pending_mask
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: two per-source result FIFOs (ALU, LSU) feeding a single
// registered register-file write port. Heads are granted round-robin when both
// are valid; pending_mask reports every destination still in flight.
module wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   wb_arbiter_if.slave bus
);

   localparam int NSRC = 2;
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = PW + 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   // Source indices double as last_grant encodings
   localparam logic [0:0] SRC_ALU = 1'b0;
   localparam logic [0:0] SRC_MEM = 1'b1;

   // Source offers gathered into arrays indexed by SRC_ALU / SRC_MEM
   logic [NSRC-1:0] in_valid;
   logic [4:0]      in_rd   [NSRC];
   logic [31:0]     in_data [NSRC];

   // FIFO storage and control
   logic [4:0]      q_rd   [NSRC][DEPTH];
   logic [31:0]     q_data [NSRC][DEPTH];
   logic [PW-1:0]   wr_ptr [NSRC];
   logic [PW-1:0]   rd_ptr [NSRC];
   logic [CW-1:0]   cnt    [NSRC];

   logic [NSRC-1:0] ready;
   logic [NSRC-1:0] push;
   logic [NSRC-1:0] pop;
   logic [NSRC-1:0] head_vld;

   logic            gnt_alu;
   logic            gnt_mem;
   logic [0:0]      last_grant;

   // Write-back stage
   logic            wb_vld_p1;
   logic [4:0]      wb_rd_p1;
   logic [31:0]     wb_data_p1;

   logic [PW-1:0]   slot_ofs;
   logic [31:0]     mask;

   assign in_valid[SRC_ALU] = bus.alu_valid;
   assign in_rd[SRC_ALU]    = bus.alu_rd;
   assign in_data[SRC_ALU]  = bus.alu_data;
   assign in_valid[SRC_MEM] = bus.mem_valid;
   assign in_rd[SRC_MEM]    = bus.mem_rd;
   assign in_data[SRC_MEM]  = bus.mem_data;

   // Ready depends on the FIFO count alone, so a full FIFO refuses even when
   // its head is being popped on the same edge.
   always_comb begin
      for (int s = 0; s < NSRC; s++) begin
         ready[s]    = (cnt[s] < CNT_FULL);
         head_vld[s] = (cnt[s] != '0);
         // rd == 0 completes the handshake but is never stored; flush drops pushes
         push[s]     = in_valid[s] && ready[s] && (in_rd[s] != 5'd0) && !bus.flush;
      end
   end

   // Round-robin grant: a lone head wins outright, a tie goes to the source
   // that did not win last time.
   always_comb begin
      gnt_alu = 1'b0;
      gnt_mem = 1'b0;
      if (!bus.flush) begin
         if (head_vld[SRC_ALU] && head_vld[SRC_MEM]) begin
            if (last_grant == SRC_MEM) gnt_alu = 1'b1;
            else                       gnt_mem = 1'b1;
         end else begin
            gnt_alu = head_vld[SRC_ALU];
            gnt_mem = head_vld[SRC_MEM];
         end
      end
   end

   assign pop[SRC_ALU] = gnt_alu;
   assign pop[SRC_MEM] = gnt_mem;

   // FIFO payload storage; contents are only meaningful below the count
   always_ff @(posedge clk) begin
      for (int s = 0; s < NSRC; s++) begin
         if (push[s]) begin
            q_rd[s][wr_ptr[s]]   <= in_rd[s];
            q_data[s][wr_ptr[s]] <= in_data[s];
         end
      end
   end

   // FIFO pointers and counts; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NSRC; s++) begin
            wr_ptr[s] <= '0;
            rd_ptr[s] <= '0;
            cnt[s]    <= '0;
         end
      end else if (bus.flush) begin
         for (int s = 0; s < NSRC; s++) begin
            wr_ptr[s] <= '0;
            rd_ptr[s] <= '0;
            cnt[s]    <= '0;
         end
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_ONE;
            if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_ONE;
            case ({push[s], pop[s]})
               2'b10:   cnt[s] <= cnt[s] + CNT_ONE;
               2'b01:   cnt[s] <= cnt[s] - CNT_ONE;
               default: cnt[s] <= cnt[s];
            endcase
         end
      end
   end

   // Fairness pointer: moves only when a grant happens, survives flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= SRC_MEM;
      end else if (gnt_alu) begin
         last_grant <= SRC_ALU;
      end else if (gnt_mem) begin
         last_grant <= SRC_MEM;
      end
   end

   // ---- stage p1: granted head registered as the register-file write ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_vld_p1  <= 1'b0;
         wb_rd_p1   <= 5'd0;
         wb_data_p1 <= 32'd0;
      end else begin
         wb_vld_p1 <= gnt_alu || gnt_mem;
         if (gnt_alu) begin
            wb_rd_p1   <= q_rd[SRC_ALU][rd_ptr[SRC_ALU]];
            wb_data_p1 <= q_data[SRC_ALU][rd_ptr[SRC_ALU]];
         end else if (gnt_mem) begin
            wb_rd_p1   <= q_rd[SRC_MEM][rd_ptr[SRC_MEM]];
            wb_data_p1 <= q_data[SRC_MEM][rd_ptr[SRC_MEM]];
         end
      end
   end

   // Pending mask from registered state only: every live FIFO slot plus the
   // write-back stage. A slot is live when its distance from the read pointer
   // is below the count.
   always_comb begin
      mask     = 32'd0;
      slot_ofs = '0;
      for (int s = 0; s < NSRC; s++) begin
         for (int j = 0; j < DEPTH; j++) begin
            slot_ofs = PW'(j) - rd_ptr[s];
            if ({1'b0, slot_ofs} < cnt[s]) mask[q_rd[s][j]] = 1'b1;
         end
      end
      if (wb_vld_p1) mask[wb_rd_p1] = 1'b1;
      mask[0] = 1'b0;
   end

   assign bus.alu_ready    = ready[SRC_ALU];
   assign bus.mem_ready    = ready[SRC_MEM];
   assign bus.wb_valid     = wb_vld_p1;
   assign bus.wb_rd        = wb_rd_p1;
   assign bus.wb_data      = wb_data_p1;
   assign bus.pending_mask = mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a table of directed vectors with hand-derived
// expectations, a per-source scoreboard that checks every write-back, and
// hand-written sequences for saturation, random traffic and mid-cycle reset.
module tb_wb_arbiter;

   logic clk;
   logic rst;

   wb_arbiter_if bus ();

   wb_arbiter #(.DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t qa[$];
   ent_t qm[$];

   int   prev_src = -1;
   bit   stress   = 1'b0;

   typedef struct {
      logic [31:0] fl, av, ar, ad, mv, mr, md;
      logic [31:0] e_ar, e_mr, e_wv, e_wr, e_wd, e_mask;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] fl, av, ar, ad, mv, mr, md);
      bus.flush     = fl[0];
      bus.alu_valid = av[0];
      bus.alu_rd    = ar[4:0];
      bus.alu_data  = ad;
      bus.mem_valid = mv[0];
      bus.mem_rd    = mr[4:0];
      bus.mem_data  = md;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic add(input logic [31:0] fl, av, ar, ad, mv, mr, md,
                      input logic [31:0] e_ar, e_mr, e_wv, e_wr, e_wd, e_mask);
      vec_t v;
      v.fl = fl; v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
      v.e_ar = e_ar; v.e_mr = e_mr; v.e_wv = e_wv; v.e_wr = e_wr; v.e_wd = e_wd;
      v.e_mask = e_mask;
      vt.push_back(v);
   endtask

   // One clock: record accepted offers, step the edge, then check any
   // write-back against the head of the matching source queue.
   task automatic cycle();
      logic acc_a, acc_m, fl;
      ent_t ea, em, got;
      int   src;
      acc_a = bus.alu_valid && bus.alu_ready && (bus.alu_rd != 5'd0);
      acc_m = bus.mem_valid && bus.mem_ready && (bus.mem_rd != 5'd0);
      fl    = bus.flush;
      ea    = '{bus.alu_rd, bus.alu_data};
      em    = '{bus.mem_rd, bus.mem_data};
      @(posedge clk);
      #1;
      if (fl) begin
         qa.delete();
         qm.delete();
      end else begin
         if (acc_a) qa.push_back(ea);
         if (acc_m) qm.push_back(em);
      end
      src = -1;
      if (bus.wb_valid) begin
         got = '{bus.wb_rd, bus.wb_data};
         n_checks++;
         if (qa.size() > 0 && qa[0] == got) begin
            src = 0;
            void'(qa.pop_front());
         end else if (qm.size() > 0 && qm[0] == got) begin
            src = 1;
            void'(qm.pop_front());
         end else begin
            n_fail++;
            $display("FAIL sb_order: write x%0d=0x%0h, expected head of a source queue (alu %0d, mem %0d entries)",
                     bus.wb_rd, bus.wb_data, qa.size(), qm.size());
         end
         if (stress && prev_src >= 0 && src >= 0)
            chk("sb_alternate", 32'(src != prev_src), 1);
      end
      prev_src = src;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_a_low, saw_m_low;

      // Vectors: flush, alu v/rd/data, mem v/rd/data,
      //          expected alu_ready, mem_ready (before edge), wb_valid/rd/data, mask (after edge)
      // Both sources on the first edge after reset: ALU wins the tie
      add(0, 1, 1, 'hA,  1, 2, 'hB,    1, 1,  0, 0, 0,      'h6);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  1, 1, 'hA,    'h6);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  1, 2, 'hB,    'h4);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  0, 0, 0,      'h0);
      // ALU x5 alone: two-edge latency, mask bit 5 for two cycles
      add(0, 1, 5, 'h11, 0, 0, 0,      1, 1,  0, 0, 0,      'h20);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  1, 5, 'h11,   'h20);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  0, 0, 0,      'h0);
      // rd == 0 is accepted and discarded
      add(0, 1, 0, 'hFF, 0, 0, 0,      1, 1,  0, 0, 0,      'h0);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  0, 0, 0,      'h0);
      // Tie after an ALU grant goes to MEM
      add(0, 1, 3, 'h33, 1, 4, 'h44,   1, 1,  0, 0, 0,      'h18);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  1, 4, 'h44,   'h18);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  1, 3, 'h33,   'h8);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  0, 0, 0,      'h0);
      // Fill both FIFOs, full ALU refuses x10, then flush with offers present
      add(0, 1, 6, 'h60, 1, 7, 'h70,   1, 1,  0, 0, 0,      'hC0);
      add(0, 1, 8, 'h80, 1, 9, 'h90,   1, 1,  1, 7, 'h70,   'h3C0);
      add(0, 1, 10,'hA0, 1, 11,'hB0,   0, 1,  1, 6, 'h60,   'hB40);
      add(1, 1, 12,'hC0, 1, 13,'hD0,   1, 0,  0, 0, 0,      'h0);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  0, 0, 0,      'h0);
      // last_grant (ALU) survived the flush, so MEM wins this tie
      add(0, 1, 14,'hE0, 1, 15,'hF0,   1, 1,  0, 0, 0,      'hC000);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  1, 15,'hF0,   'hC000);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  1, 14,'hE0,   'h4000);
      add(0, 0, 0, 0,    0, 0, 0,      1, 1,  0, 0, 0,      'h0);

      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset alu_ready",    32'(bus.alu_ready), 1);
      chk("reset mem_ready",    32'(bus.mem_ready), 1);
      chk("reset pending_mask", bus.pending_mask, 0);
      chk("reset wb_valid",     32'(bus.wb_valid), 0);
      chk("reset wb_rd",        32'(bus.wb_rd), 0);
      chk("reset wb_data",      bus.wb_data, 0);
      rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].fl, vt[i].av, vt[i].ar, vt[i].ad, vt[i].mv, vt[i].mr, vt[i].md);
         chk($sformatf("v%0d alu_ready", i), 32'(bus.alu_ready), vt[i].e_ar);
         chk($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), vt[i].e_mr);
         cycle();
         chk($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), vt[i].e_wv);
         if (vt[i].e_wv[0]) begin
            chk($sformatf("v%0d wb_rd", i),   32'(bus.wb_rd), vt[i].e_wr);
            chk($sformatf("v%0d wb_data", i), bus.wb_data,    vt[i].e_wd);
         end
         chk($sformatf("v%0d pending_mask", i), bus.pending_mask, vt[i].e_mask);
      end

      // Both sources offer every cycle: grants alternate, readies drop at full
      stress    = 1'b1;
      saw_a_low = 1'b0;
      saw_m_low = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 32'(i % 31 + 1), 32'hA000_0000 + 32'(i),
               1, 32'((i + 7) % 31 + 1), 32'hB000_0000 + 32'(i));
         if (!bus.alu_ready) saw_a_low = 1'b1;
         if (!bus.mem_ready) saw_m_low = 1'b1;
         cycle();
      end
      stress = 1'b0;
      idle();
      repeat (6) cycle();
      chk("stress alu_ready dropped", 32'(saw_a_low), 1);
      chk("stress mem_ready dropped", 32'(saw_m_low), 1);
      chk("stress alu results lost", 32'(qa.size()), 0);
      chk("stress mem results lost", 32'(qm.size()), 0);

      // Random traffic with occasional rd == 0 and flush
      for (int i = 0; i < 300; i++) begin
         drive(32'($urandom_range(0, 24) == 0),
               32'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom,
               32'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom);
         cycle();
      end
      idle();
      repeat (6) cycle();
      chk("random alu results lost", 32'(qa.size()), 0);
      chk("random mem results lost", 32'(qm.size()), 0);
      chk("random idle mask",        bus.pending_mask, 0);

      // Reset between edges with results in flight
      drive(0, 1, 20, 32'h200, 1, 21, 32'h210);
      cycle();
      drive(0, 1, 22, 32'h220, 1, 23, 32'h230);
      cycle();
      chk("pre-reset wb_valid",  32'(bus.wb_valid), 1);
      chk("pre-reset mask busy", 32'(bus.pending_mask != 0), 1);
      #2 rst = 1'b1;
      #1;
      chk("async reset wb_valid",     32'(bus.wb_valid), 0);
      chk("async reset wb_rd",        32'(bus.wb_rd), 0);
      chk("async reset wb_data",      bus.wb_data, 0);
      chk("async reset pending_mask", bus.pending_mask, 0);
      chk("async reset alu_ready",    32'(bus.alu_ready), 1);
      chk("async reset mem_ready",    32'(bus.mem_ready), 1);
      qa.delete();
      qm.delete();
      idle();
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("post-reset wb_valid %0d", i), 32'(bus.wb_valid), 0);
         chk($sformatf("post-reset mask %0d", i),     bus.pending_mask, 0);
      end

      // First tie after reset goes to ALU
      drive(0, 1, 24, 32'h240, 1, 25, 32'h250);
      cycle();
      idle();
      cycle();
      chk("tie after reset wb_rd",   32'(bus.wb_rd), 24);
      chk("tie after reset wb_data", bus.wb_data, 32'h240);
      cycle();
      chk("tie after reset second wb_rd", 32'(bus.wb_rd), 25);
      cycle();
      chk("final wb_valid", 32'(bus.wb_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, per-source result FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous clear of all queued and staged results.
REQ-005 SHALL have ports alu_valid input 1, alu_rd input 5, alu_data input 32: ALU result offer.
REQ-006 SHALL have port alu_ready  output  1  ALU FIFO can accept this cycle.
REQ-007 SHALL have ports mem_valid input 1, mem_rd input 5, mem_data input 32: LSU result offer.
REQ-008 SHALL have port mem_ready  output  1  LSU FIFO can accept this cycle.
REQ-009 SHALL have ports wb_valid output 1, wb_rd output 5, wb_data output 32: registered register-file write.
REQ-010 SHALL have port pending_mask  output  32  bit r set while a write to xr is queued or staged.

Function
REQ-011 SHALL accept a source result on a rising edge when its valid and ready are both high.
REQ-012 SHALL drive x_ready = (FIFO count < DEPTH), combinational from count only; no accept-when-full even if the same edge pops.
REQ-013 SHALL discard an accepted result with rd == 0 (handshake completes, nothing enqueued).
REQ-014 SHALL keep strict FIFO order within each source.
REQ-015 SHALL grant at most one FIFO head per cycle to the output stage.
REQ-016 SHALL grant the only non-empty source when exactly one head is valid.
REQ-017 SHALL grant round-robin when both heads are valid: the source not granted last; last_grant updates only on a grant.
REQ-018 SHALL pop the granted head and register it into wb_valid/wb_rd/wb_data on the same edge.
REQ-019 SHALL deassert wb_valid on any edge with no grant (wb_rd/wb_data hold value, don't-care).
REQ-020 SHALL give a two-edge latency: accept at edge N into empty FIFO, no contention -> wb_valid high after edge N+1.
REQ-021 SHALL allow push and pop of the same FIFO on one edge; count unchanged.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-023 SHALL set pending_mask bit r iff any valid entry of either FIFO, or the wb stage with wb_valid high, has rd == r; bit 0 always 0.
REQ-024 SHALL compute pending_mask combinationally from registered state (no input-to-mask path).
REQ-025 SHALL on flush high at an edge: empty both FIFOs, clear wb_valid, ignore that edge's pushes, keep last_grant.
REQ-026 SHALL not detect duplicate rd across sources; dispatcher uses pending_mask to prevent them.

Reset
REQ-027 SHALL on rst high immediately (asynchronously) clear both FIFO counts and pointers, wb_valid=0, wb_rd=0, wb_data=0, last_grant=MEM.
REQ-028 SHALL drive alu_ready=1, mem_ready=1, pending_mask=0 while in reset and after release.
REQ-029 SHALL abort in-flight results on reset mid-operation; no write appears after release.
REQ-030 SHALL give ALU the first tie after reset (last_grant=MEM).

Verification
REQ-031 SHALL cover: ALU x5=0x11 alone at edge 0 -> wb_valid, wb_rd=5, wb_data=0x11 after edge 1; pending_mask bit5 set after edge 0, clear after edge 2.
REQ-032 SHALL cover: ALU x1=0xA and MEM x2=0xB same edge after reset -> writes x1 then x2 on consecutive cycles.
REQ-033 SHALL cover: both sources push every cycle, DEPTH=2 -> grants alternate ALU/MEM, each ready drops when count=2, no result lost or reordered.
REQ-034 SHALL cover: ALU rd=0 data 0xFF -> alu_ready handshake completes, no wb_valid, pending_mask stays 0.
REQ-035 SHALL cover: two entries queued per source, flush pulse -> wb_valid 0 next cycle, mask 0, both ready=1, flush-cycle pushes dropped.
REQ-036 SHALL cover: rst asserted between edges with entries queued -> outputs reset without a clock edge; no writes after release.
